// File: rtl/zone_scheduler.sv
// -----------------------------------------------------------------------------
// zone_scheduler
//
// Loads a small irrigation schedule from an external line parser and then
// drives one valve at a time from the current time of day.
//
// A load pulse starts a fetch. The block holds read_next_line high and
// captures NUM_LINES parsed lines into a four-entry zone table. It then
// idles for one gap cycle and enters RUN. In RUN the lowest-index zone whose
// [start, stop) window contains cur_time gets its valve bit set. Only one
// valve is ever open at a time, because there is a single pump.
//
// Optional feature (macro ZONE_SCHED_TIMEOUT_EN):
//   When the macro is defined, the fetch gives up after FETCH_TIMEOUT cycles
//   with no data_valid. It raises err and runs with the lines captured so far.
//   When the macro is undefined, the fetch waits for data_valid forever.
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   synchronous active-high reset
//   load           in   one-cycle pulse: start / restart a schedule load
//   cur_time       in   [31:0] current time of day
//   read_next_line out  request to the parser, high while fetching
//   data_valid     in   parser strobe for zone/start_time/stop_time
//   zone           in   [1:0] zone index of the parsed line
//   start_time     in   [31:0] on-time of the parsed line
//   stop_time      in   [31:0] off-time of the parsed line (exclusive)
//   valve          out  [3:0] one-hot valve drive
//   busy           out  high while fetching
//   load_done      out  one-cycle pulse on the first RUN cycle
//   err            out  sticky error (bad line or fetch timeout)
// -----------------------------------------------------------------------------
module zone_scheduler #(
    parameter int NUM_LINES     = 4,
    parameter int FETCH_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] cur_time,
    output logic        read_next_line,
    input  logic        data_valid,
    input  logic [1:0]  zone,
    input  logic [31:0] start_time,
    input  logic [31:0] stop_time,
    output logic [3:0]  valve,
    output logic        busy,
    output logic        load_done,
    output logic        err
);

    // Reject out-of-range parameter values when the design is elaborated.
    if (NUM_LINES < 1 || NUM_LINES > 16 || FETCH_TIMEOUT < 1) begin : g_param_check
        $error("zone_scheduler: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_GAP   = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    localparam logic [4:0] LAST_LINE = 5'(NUM_LINES - 1);

    state_t      state_q, state_d;
    logic [4:0]  line_cnt_q, line_cnt_d;
    logic        err_q, err_d;
    logic [3:0]  valve_q, valve_d;
    logic        load_done_q, load_done_d;
    logic [3:0]  en_q, en_d;
    logic [31:0] start_q [4];
    logic [31:0] stop_q  [4];

    logic        capture;
    logic        last_line;
    logic        timeout_hit;
    logic        entry_ok;
    logic [3:0]  eligible;
    logic [3:0]  grant;

    // A load in the same cycle as data_valid restarts the fetch.
    // The line is then dropped instead of being captured.
    assign capture   = (state_q == S_FETCH) && data_valid && !load;
    assign last_line = (line_cnt_q == LAST_LINE);
    assign entry_ok  = (start_time < stop_time);

`ifdef ZONE_SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FETCH_TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Counts idle cycles since FETCH entry or since the last data_valid.
    // It reaches its limit on the FETCH_TIMEOUT-th consecutive idle cycle.
    assign timeout_hit = (state_q == S_FETCH) && !load && !data_valid && (tmo_q == TMO_LAST);

    always_comb begin
        tmo_d = '0;
        if (state_q == S_FETCH && !load && !data_valid) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Zone z is eligible when it is enabled and start <= cur_time < stop.
    for (genvar gi = 0; gi < 4; gi++) begin : g_elig
        assign eligible[gi] = en_q[gi] && (start_q[gi] <= cur_time) && (cur_time < stop_q[gi]);
    end

    // Keep only the lowest set bit, so the lowest-index eligible zone wins the pump.
    assign grant = eligible & (~eligible + 4'd1);

    // ---------------------------------------------------------------- FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (load) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (load) begin
                    state_d = S_FETCH;
                end else if ((capture && last_line) || timeout_hit) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                state_d = load ? S_FETCH : S_RUN;
            end
            S_RUN: begin
                state_d = load ? S_FETCH : S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- FSM: outputs
    always_comb begin
        read_next_line = 1'b0;
        busy           = 1'b0;
        if (state_q == S_FETCH) begin
            read_next_line = 1'b1;
            busy           = 1'b1;
        end
    end

    assign valve     = valve_q;
    assign load_done = load_done_q;
    assign err       = err_q;

    // ---------------------------------------------------------------- datapath next state
    always_comb begin
        line_cnt_d  = line_cnt_q;
        err_d       = err_q;
        en_d        = en_q;
        valve_d     = 4'b0000;
        load_done_d = 1'b0;
        if (load) begin
            // Any load starts a fresh table.
            // The start/stop words are stale but harmless while en is clear.
            line_cnt_d = '0;
            err_d      = 1'b0;
            en_d       = 4'b0000;
        end else begin
            if (capture) begin
                line_cnt_d = line_cnt_q + 5'd1;
                en_d[zone] = entry_ok;
                if (!entry_ok) err_d = 1'b1;
            end
            if (timeout_hit) err_d = 1'b1;
            if (state_q == S_GAP) load_done_d = 1'b1;
            if (state_q == S_RUN) valve_d = grant;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_cnt_q  <= '0;
            err_q       <= 1'b0;
            en_q        <= 4'b0000;
            valve_q     <= 4'b0000;
            load_done_q <= 1'b0;
        end else begin
            line_cnt_q  <= line_cnt_d;
            err_q       <= err_d;
            en_q        <= en_d;
            valve_q     <= valve_d;
            load_done_q <= load_done_d;
        end
    end

    // Table words carry no reset.
    // An entry only matters once its en bit has been set by a capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            start_q[zone] <= start_time;
            stop_q[zone]  <= stop_time;
        end
    end

endmodule

// File: doc/zone_scheduler.md
ZONE_SCHEDULER -- requirements
Module: zone_scheduler

Interface
REQ-001 Parameter NUM_LINES, default 4: schedule lines fetched per load (1..16).
REQ-002 Parameter FETCH_TIMEOUT, default 64: max cycles between data_valid pulses while fetching.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 load  input  1  single-cycle pulse; starts a schedule (re)load.
REQ-006 cur_time  input  32  current time of day, same encoding as start/stop times.
REQ-007 read_next_line  output  1  request to line parser; held high while fetching.
REQ-008 data_valid  input  1  parser strobe; zone/start_time/stop_time are valid this cycle.
REQ-009 zone  input  2  zone index of the parsed line.
REQ-010 start_time  input  32  parsed on-time.
REQ-011 stop_time  input  32  parsed off-time, exclusive.
REQ-012 valve  output  4  one-hot valve drive; at most one bit set.
REQ-013 busy  output  1  high in FETCH.
REQ-014 load_done  output  1  one-cycle pulse on FETCH->RUN.
REQ-015 err  output  1  sticky error flag; cleared by load or rst.

Function
REQ-016 FSM states IDLE, FETCH, GAP, RUN; reset state IDLE.
REQ-017 IDLE: valve=0, read_next_line=0; load -> FETCH.
REQ-018 FETCH: read_next_line=1; each data_valid stores entry: table[zone].start/stop <= inputs, table[zone].en <= (start_time < stop_time).
REQ-019 Line counter increments per data_valid; after the NUM_LINES-th capture, read_next_line drops next cycle and FSM -> GAP.
REQ-020 GAP: exactly one cycle with read_next_line=0, letting the parser return to its idle state; then -> RUN with load_done=1 for that cycle.
REQ-021 Duplicate zone within one load: later line overwrites earlier entry; counter still increments.
REQ-022 Entry with start_time >= stop_time is stored disabled and sets err.
REQ-023 load entering FETCH clears all table en bits, the line counter and err.
REQ-024 RUN: zone z is eligible when en[z] and start[z] <= cur_time < stop[z] (unsigned 32-bit compares).
REQ-025 Single-pump rule: among eligible zones the lowest index wins; valve is registered, one-cycle latency from cur_time.
REQ-026 No eligible zone -> valve=0 next cycle.
REQ-027 load in RUN or FETCH: valve=0 and FSM -> FETCH next cycle (restart); load in GAP is handled as in RUN.
REQ-028 data_valid outside FETCH is ignored.
REQ-029 busy=1 exactly when state is FETCH.

Reset
REQ-030 rst: state IDLE; valve=0, read_next_line=0, busy=0, load_done=0, err=0; all en bits, line counter and timeout counter zero.
REQ-031 rst mid-FETCH abandons the fetch; the table is not retained.

Configuration
REQ-032 Macro ZONE_SCHED_TIMEOUT_EN defined: in FETCH a counter resets on each data_valid; on reaching FETCH_TIMEOUT cycles without data_valid, err=1 and FSM -> GAP -> RUN using entries captured so far.
REQ-033 Macro undefined: no timeout counter; FETCH waits for data_valid indefinitely.

Verification
REQ-034 load; 4 lines z0 0800-0900, z1 0900-1000, z2 1000-1100, z3 1100-1200 -> load_done after 4th capture + GAP; cur_time 0830 -> valve=0001; 0930 -> 0010; 1200 -> 0000.
REQ-035 Overlap: z1 0800-1000, z2 0700-0900; cur_time 0830 -> valve=0010 (lowest index); 0730 -> 0100.
REQ-036 Bad line z2 1000-0900 -> err=1, z2 never on; next load clears err.
REQ-037 load pulsed during RUN with valve=0001 -> valve=0000 next cycle, busy=1, read_next_line=1.
REQ-038 Timeout macro on, FETCH_TIMEOUT=64, only 2 lines delivered -> err=1 64 cycles after 2nd capture, RUN entered, captured zones operate.
REQ-039 rst asserted in FETCH after 2 captures -> IDLE, all outputs zero, cur_time in range of a captured zone -> valve=0.
